// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution block: condition-code
// encodings (instruction bits [31:28]) and bit positions inside the
// architectural {N,Z,C,V} flags register.
package cond_pkg;

  // Condition-code field encodings.
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Flag bit positions inside the 4-bit flags vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational condition evaluator: decides whether an instruction's
// condition field passes against the current architectural flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx_raw
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // Decode the condition field into a pass/fail against the flag values.
  always_comb begin
    CondEx_raw = 1'b0;
    case (cond_e'(Cond))
      COND_EQ: CondEx_raw = z;
      COND_NE: CondEx_raw = ~z;
      COND_CS: CondEx_raw = c;
      COND_CC: CondEx_raw = ~c;
      COND_MI: CondEx_raw = n;
      COND_PL: CondEx_raw = ~n;
      COND_VS: CondEx_raw = v;
      COND_VC: CondEx_raw = ~v;
      COND_HI: CondEx_raw = c & ~z;
      COND_LS: CondEx_raw = ~c | z;
      COND_GE: CondEx_raw = (n == v);
      COND_LT: CondEx_raw = (n != v);
      COND_GT: CondEx_raw = ~z & (n == v);
      COND_LE: CondEx_raw = z | (n != v);
      COND_AL: CondEx_raw = 1'b1;
      COND_NV: CondEx_raw = 1'b0;
      default: CondEx_raw = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution unit: gates the decoder's write intents with the
// condition result, owns the architectural {N,Z,C,V} flags register and a
// saturating count of condition-failed instructions.
// Optional macro COND_STALL_EN adds a Stall input that freezes state and
// suppresses all write enables while asserted.
module cond_logic
  import cond_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
`ifdef COND_STALL_EN
  input  logic        Stall,
`endif
  input  logic [3:0]  Cond,
  input  logic [3:0]  ALUFlags,
  input  logic [1:0]  FlagW,
  input  logic        PCS,
  input  logic        RegW,
  input  logic        MemW,
  input  logic        Flush,
  output logic        PCSrc,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        CondEx,
  output logic [3:0]  Flags,
  output logic [15:0] SkipCnt
);

  logic [3:0]  flags_q, flags_d;
  logic [15:0] skipCnt_q, skipCnt_d;
  logic        condExRaw;
  logic        stallActive;
  logic        anyIntent;
  logic        skipEvent;

`ifdef COND_STALL_EN
  assign stallActive = Stall;
`else
  assign stallActive = 1'b0;
`endif

  // Condition is evaluated against the registered flags only, so a flag
  // write becomes visible one instruction later.
  cond_check u_cond_check (
    .Cond       (Cond),
    .Flags      (flags_q),
    .CondEx_raw (condExRaw)
  );

  assign CondEx   = condExRaw & ~Flush & ~stallActive;
  assign PCSrc    = PCS  & CondEx;
  assign RegWrite = RegW & CondEx;
  assign MemWrite = MemW & CondEx;

  // A skip is a real instruction (some intent present) whose condition
  // failed; flushed or stalled slots are not counted.
  assign anyIntent = PCS | RegW | MemW | (|FlagW);
  assign skipEvent = ~condExRaw & ~Flush & ~stallActive & anyIntent;

  // Next-state for the flag halves and the saturating skip counter.
  always_comb begin
    flags_d   = flags_q;
    skipCnt_d = skipCnt_q;
    if (FlagW[1] & CondEx) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (FlagW[0] & CondEx) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
    if (skipEvent && (skipCnt_q != 16'hFFFF)) begin
      skipCnt_d = skipCnt_q + 16'd1;
    end
  end

  // State registers with synchronous reset overriding any pending update.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      skipCnt_q <= 16'd0;
    end else begin
      flags_q   <= flags_d;
      skipCnt_q <= skipCnt_d;
    end
  end

  assign Flags   = flags_q;
  assign SkipCnt = skipCnt_q;

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: a behavioural model of the flags and
// skip counter is compared against the DUT every cycle, alongside a few
// directed scenarios with literal expectations.
module tb_cond_logic;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  Cond;
  logic [3:0]  ALUFlags;
  logic [1:0]  FlagW;
  logic        PCS, RegW, MemW, Flush;
  logic        PCSrc, RegWrite, MemWrite, CondEx;
  logic [3:0]  Flags;
  logic [15:0] SkipCnt;
`ifdef COND_STALL_EN
  logic        Stall = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  logic [3:0] mFlags;
  int         mSkip;

  always #5 clk = ~clk;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
`ifdef COND_STALL_EN
    .Stall    (Stall),
`endif
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .Flush    (Flush),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .CondEx   (CondEx),
    .Flags    (Flags),
    .SkipCnt  (SkipCnt)
  );

  // Condition table written directly from the architectural definitions.
  function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] c, input logic [3:0] alu,
                               input logic [1:0] fw, input logic pcs, input logic regw,
                               input logic memw, input logic fl);
    @(posedge clk);
    #1;
    reset = rst; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; Flush = fl;
  endtask

  // Reference model: architectural flags and saturating skip count.
  always @(posedge clk) begin : model
    bit pass, intent;
    if (reset) begin
      mFlags <= 4'b0000;
      mSkip  <= 0;
    end else begin
      pass   = condHolds(Cond, mFlags) && !Flush;
      intent = PCS || RegW || MemW || (FlagW != 2'b00);
      if (pass && FlagW[1]) mFlags[3:2] <= ALUFlags[3:2];
      if (pass && FlagW[0]) mFlags[1:0] <= ALUFlags[1:0];
      if (!condHolds(Cond, mFlags) && !Flush && intent && mSkip < 65535)
        mSkip <= mSkip + 1;
    end
  end

  // Per-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin : compare
    bit ex;
    if (checkEn) begin
      ex = condHolds(Cond, mFlags) && !Flush;
      checkOutput("CondEx",   CondEx,   ex);
      checkOutput("PCSrc",    PCSrc,    ex && PCS);
      checkOutput("RegWrite", RegWrite, ex && RegW);
      checkOutput("MemWrite", MemWrite, ex && MemW);
      checkOutput("Flags",    Flags,    mFlags);
      checkOutput("SkipCnt",  SkipCnt,  mSkip);
    end
  end

  initial begin
    reset = 1'b1; Cond = 4'd14; ALUFlags = 4'd0; FlagW = 2'b00;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; Flush = 1'b0;

    applyStimulus(1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);
    checkEn = 1'b1;
    applyStimulus(1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0);

    // After reset: unconditional writes pass, state cleared.
    applyStimulus(0, 4'hE, 4'h0, 2'b00, 0, 1, 1, 0);
    #1;
    checkOutput("rst_RegWrite", RegWrite, 1);
    checkOutput("rst_MemWrite", MemWrite, 1);
    checkOutput("rst_Flags",    Flags,    4'b0000);
    checkOutput("rst_SkipCnt",  SkipCnt,  0);

    // Z update visible next cycle; EQ passes, NE fails and is counted.
    applyStimulus(0, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 4'h0, 4'h0, 2'b00, 1, 0, 0, 0);
    #1;
    checkOutput("z_Flags", Flags, 4'b0100);
    checkOutput("eq_PCSrc", PCSrc, 1);
    applyStimulus(0, 4'h1, 4'h0, 2'b00, 0, 1, 0, 0);
    #1;
    checkOutput("ne_RegWrite", RegWrite, 0);
    applyStimulus(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("ne_SkipCnt", SkipCnt, 1);

    // N=1,V=0: LT passes, GE fails, NV never.
    applyStimulus(0, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
    applyStimulus(0, 4'hB, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("nv_Flags", Flags, 4'b1000);
    checkOutput("lt_CondEx", CondEx, 1);
    applyStimulus(0, 4'hA, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("ge_CondEx", CondEx, 0);
    applyStimulus(0, 4'hF, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("nvr_CondEx", CondEx, 0);

    // Partial N,Z update; then a failed condition leaves flags alone.
    applyStimulus(0, 4'hE, 4'b1111, 2'b10, 0, 0, 0, 0);
    applyStimulus(0, 4'h1, 4'b0011, 2'b11, 0, 0, 0, 0);
    #1;
    checkOutput("nz_Flags", Flags, 4'b1100);
    checkOutput("fail_CondEx", CondEx, 0);
    applyStimulus(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("fail_Flags",   Flags,   4'b1100);
    checkOutput("fail_SkipCnt", SkipCnt, 2);

    // Flush kills the instruction without counting it.
    applyStimulus(0, 4'hE, 4'b0000, 2'b11, 0, 1, 0, 1);
    #1;
    checkOutput("flush_RegWrite", RegWrite, 0);
    applyStimulus(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("flush_Flags",   Flags,   4'b1100);
    checkOutput("flush_SkipCnt", SkipCnt, 2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0));
    end

    // Saturation: 65536 never-executing instructions from a clean state.
    applyStimulus(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(0, 4'hF, 4'($urandom_range(0, 15)), 2'b00, 0, 1, 0, 0);
    end
    applyStimulus(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("sat_SkipCnt", SkipCnt, 16'hFFFF);
    applyStimulus(1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
    #1;
    checkOutput("rstpend_CondEx", CondEx, 1);
    applyStimulus(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    #1;
    checkOutput("rstpend_Flags",   Flags,   4'b0000);
    checkOutput("rstpend_SkipCnt", SkipCnt, 0);

    applyStimulus(0, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0);
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cond_logic.md
COND_LOGIC -- requirements
Module: cond_logic

Interface
REQ-001 The block SHALL have port clk, input, 1 bit, the single clock; every register updates on its rising edge.
REQ-002 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL have port Cond, input, 4 bits, the instruction condition field [31:28].
REQ-004 The block SHALL have port ALUFlags, input, 4 bits, the ALU result flags {N,Z,C,V} for the current instruction.
REQ-005 The block SHALL have port FlagW, input, 2 bits, from the main/ALU decoder: bit1 requests an N,Z update and bit0 requests a C,V update.
REQ-006 The block SHALL have ports PCS, RegW and MemW, inputs, 1 bit each, the unconditional decoder intents.
REQ-007 The block SHALL have port Flush, input, 1 bit, which kills the current instruction.
REQ-008 The block SHALL have ports PCSrc, RegWrite and MemWrite, outputs, 1 bit each, the condition-gated write enables.
REQ-009 The block SHALL have port CondEx, output, 1 bit, which is 1 when the condition passed and no Flush is present.
REQ-010 The block SHALL have port Flags, output, 4 bits, the architectural {N,Z,C,V} register.
REQ-011 The block SHALL have port SkipCnt, output, 16 bits, the count of condition-failed instructions.

Function
REQ-012 The block SHALL evaluate CondEx combinationally from Cond and the registered Flags (not ALUFlags), with zero latency.
REQ-013 Condition codes SHALL decode as: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
REQ-014 Condition codes SHALL further decode as: 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0 (never executes).
REQ-015 The gated outputs SHALL be PCSrc=PCS&CondEx, RegWrite=RegW&CondEx and MemWrite=MemW&CondEx, all combinational.
REQ-016 Flags[3:2] SHALL load ALUFlags[3:2] at the clock edge only when FlagW[1]&CondEx is 1, and SHALL hold otherwise.
REQ-017 Flags[1:0] SHALL load ALUFlags[1:0] at the clock edge only when FlagW[0]&CondEx is 1, and SHALL hold otherwise.
REQ-018 A flag update SHALL become visible to the condition evaluation of the next cycle's instruction; there is no same-cycle bypass.
REQ-019 Flush=1 SHALL force CondEx=0, which suppresses all writes and flag updates; Flush SHALL NOT increment SkipCnt.
REQ-020 SkipCnt SHALL increment by 1 when condition evaluation is 0, Flush=0, and at least one of PCS, RegW, MemW or FlagW is nonzero.
REQ-021 SkipCnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-022 A flag update and a SkipCnt increment in the same cycle are mutually exclusive by construction; no arbitration SHALL be required.

Reset
REQ-023 When reset=1 at a clock edge, Flags SHALL become 4'b0000 and SkipCnt SHALL become 0, overriding every update in that cycle.
REQ-024 During reset, the combinational outputs SHALL still follow REQ-012 to REQ-015 using Flags=0.
REQ-025 Reset asserted mid-sequence SHALL discard any pending flag write of that cycle.

Configuration
REQ-026 Macro COND_STALL_EN, when defined, SHALL add input Stall (1 bit).
REQ-027 With COND_STALL_EN defined, Stall=1 SHALL freeze Flags and SkipCnt and SHALL force CondEx, PCSrc, RegWrite and MemWrite to 0.
REQ-028 With COND_STALL_EN defined, reset SHALL still take priority over Stall.
REQ-029 Without COND_STALL_EN, the port SHALL be absent and behaviour SHALL be as if Stall=0.

Structure
REQ-030 Package cond_pkg SHALL hold the 4-bit condition-code constants (COND_EQ..COND_NV) and the flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
REQ-031 Sub-module cond_check SHALL be purely combinational, mapping Cond and Flags to CondEx_raw; cond_logic SHALL hold the registers, gating, Flush/Stall handling and counter.

Verification
REQ-032 The bench SHALL cover: after reset, Cond=1110, RegW=1, MemW=1 -> RegWrite=1, MemWrite=1, Flags=0000, SkipCnt=0.
REQ-033 The bench SHALL cover: Cond=1110, FlagW=11, ALUFlags=0100 at one edge -> Flags=0100 the next cycle; then Cond=0000, PCS=1 -> PCSrc=1, and Cond=0001, RegW=1 -> RegWrite=0 with SkipCnt=1.
REQ-034 The bench SHALL cover: Flags=1000 (N=1, V=0) with Cond=1011 -> CondEx=1; with Cond=1010 -> CondEx=0; with Cond=1111 -> CondEx=0.
REQ-035 The bench SHALL cover: FlagW=10, ALUFlags=1111, Cond=1110 -> Flags=11xx with C,V unchanged; a failed Cond with FlagW=11 -> Flags unchanged.
REQ-036 The bench SHALL cover: Flush=1 with Cond=1110, RegW=1, FlagW=11 -> RegWrite=0, Flags unchanged, SkipCnt unchanged.
REQ-037 The bench SHALL cover: preload via 65536 failed instructions -> SkipCnt=FFFF held; then reset=1 with FlagW=11 -> Flags=0000, SkipCnt=0.
